// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic sequencer: state codes, lamp codes,
// counter width and the state-to-lamp decode.
package traffic_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        AR2  = 3'd0,
        MG   = 3'd1,
        MY   = 3'd2,
        AR1  = 3'd3,
        SG   = 3'd4,
        SY   = 3'd5,
        WALK = 3'd6,
        EMRG = 3'd7
    } state_t;

    localparam logic [3:0] L_R  = 4'b1000;
    localparam logic [3:0] L_Y  = 4'b0100;
    localparam logic [3:0] L_G  = 4'b0010;
    localparam logic [3:0] L_RP = 4'b1001;

    typedef struct packed {
        logic [3:0] main_l;
        logic [3:0] side_l;
    } lights_t;

    function automatic lights_t decode_lights(input state_t s);
        lights_t l;
        l = '{main_l: L_R, side_l: L_R};
        case (s)
            MG:      l = '{main_l: L_G,  side_l: L_R};
            MY:      l = '{main_l: L_Y,  side_l: L_R};
            SG:      l = '{main_l: L_R,  side_l: L_G};
            SY:      l = '{main_l: L_R,  side_l: L_Y};
            WALK:    l = '{main_l: L_RP, side_l: L_RP};
            default: l = '{main_l: L_R,  side_l: L_R};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable dwell down-counter; decrements only on tick, flags zero.
module phase_timer
    import traffic_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= RST_VAL;
        else if (load)
            count <= load_val;
        else if (tick && (count != '0))
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/traffic_sequencer.sv
// Two-road traffic light sequencer with pedestrian walk phase and
// emergency preemption; lamps are decoded from the registered state only.
module traffic_sequencer
    import traffic_pkg::*;
#(
    parameter int T_GREEN  = 8,
    parameter int T_YELLOW = 2,
    parameter int T_ALLRED = 1,
    parameter int T_WALK   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       emerg,
    output logic [3:0] main_light,
    output logic [3:0] side_light,
    output logic       ped_ack,
    output logic [2:0] phase
);

    state_t           state, st_nxt;
    logic             zero, expire, load, walk_entry;
    logic [CNT_W-1:0] load_val;
    logic             ped_latch, emerg_pend;
    lights_t          lamps;

    function automatic logic [CNT_W-1:0] dwell_m1(input state_t s);
        case (s)
            MG, SG:  return CNT_W'(T_GREEN - 1);
            MY, SY:  return CNT_W'(T_YELLOW - 1);
            WALK:    return CNT_W'(T_WALK - 1);
            default: return CNT_W'(T_ALLRED - 1);
        endcase
    endfunction

    phase_timer #(
        .RST_VAL (CNT_W'(T_ALLRED - 1))
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .zero     (zero)
    );

    always_comb begin
        expire = tick & zero;
        st_nxt = state;
        case (state)
            MG:   if (emerg || expire) st_nxt = MY;
            SG:   if (emerg || expire) st_nxt = SY;
            // yellow always completes; a preempt seen during it redirects the exit
            MY:   if (expire) st_nxt = (emerg || emerg_pend) ? EMRG : AR1;
            SY:   if (expire) st_nxt = (emerg || emerg_pend) ? EMRG : AR2;
            AR1:  if (emerg) st_nxt = EMRG; else if (expire) st_nxt = SG;
            AR2:  if (emerg) st_nxt = EMRG;
                  else if (expire) st_nxt = ped_latch ? WALK : MG;
            WALK: if (emerg) st_nxt = EMRG; else if (expire) st_nxt = MG;
            EMRG: if (!emerg && expire) st_nxt = MG;
            default: st_nxt = AR2;
        endcase
        load       = (st_nxt != state) || ((state == EMRG) && emerg);
        load_val   = dwell_m1(st_nxt);
        walk_entry = (st_nxt == WALK) && (state != WALK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= AR2;
            ped_latch  <= 1'b0;
            emerg_pend <= 1'b0;
            ped_ack    <= 1'b0;
        end else begin
            state      <= st_nxt;
            ped_latch  <= walk_entry ? 1'b0 : (ped_latch | ped_req);
            emerg_pend <= ((st_nxt == MY) || (st_nxt == SY)) && (emerg_pend || emerg);
            ped_ack    <= walk_entry;
        end
    end

    assign lamps      = decode_lights(state);
    assign main_light = lamps.main_l;
    assign side_light = lamps.side_l;
    assign phase      = state;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Directed bench for traffic_sequencer: phase durations, walk, preemption,
// slow tick and asynchronous reset.
module tb_traffic_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, tick, ped_req, emerg;
    logic [3:0] main_light, side_light;
    logic       ped_ack;
    logic [2:0] phase;

    int n_cmp = 0;
    int n_err = 0;
    int ack_cnt = 0;
    int a0;
    bit mode3 = 1'b0;
    int divc = 0;

    traffic_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .ped_req    (ped_req),
        .emerg      (emerg),
        .main_light (main_light),
        .side_light (side_light),
        .ped_ack    (ped_ack),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // advance one cycle; inputs and samples sit 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
        if (mode3) begin
            divc = (divc + 1) % 3;
            tick = (divc == 2);
        end
    endtask

    task automatic expect_phase(input string tag, input int ph, input int len,
                                input int ml, input int sl);
        int n;
        n = 0;
        chk({tag, ".phase"}, phase, ph);
        chk({tag, ".main"}, main_light, ml);
        chk({tag, ".side"}, side_light, sl);
        while (phase == 3'(ph) && n < 300) begin
            if (ped_ack) ack_cnt++;
            step();
            n++;
        end
        chk({tag, ".len"}, n, len);
    endtask

    task automatic normal_cycle_from_mg(input string tag);
        expect_phase({tag, ".MG"},  1, 8, 4'b0010, 4'b1000);
        expect_phase({tag, ".MY"},  2, 2, 4'b0100, 4'b1000);
        expect_phase({tag, ".AR1"}, 3, 1, 4'b1000, 4'b1000);
        expect_phase({tag, ".SG"},  4, 8, 4'b1000, 4'b0010);
        expect_phase({tag, ".SY"},  5, 2, 4'b1000, 4'b0100);
        expect_phase({tag, ".AR2"}, 0, 1, 4'b1000, 4'b1000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; tick = 1'b0; ped_req = 1'b0; emerg = 1'b0;
        #1;
        chk("rst.async_phase", phase, 0);
        repeat (3) step();
        chk("rst.phase", phase, 0);
        chk("rst.main", main_light, 4'b1000);
        chk("rst.side", side_light, 4'b1000);
        chk("rst.ack", ped_ack, 0);

        // basic cycle, tick every cycle
        tick = 1'b1;
        rst_n = 1'b1;
        expect_phase("t1.AR2", 0, 1, 4'b1000, 4'b1000);
        normal_cycle_from_mg("t1");

        // pedestrian request during side green
        expect_phase("t2.MG",  1, 8, 4'b0010, 4'b1000);
        expect_phase("t2.MY",  2, 2, 4'b0100, 4'b1000);
        expect_phase("t2.AR1", 3, 1, 4'b1000, 4'b1000);
        chk("t2.sg", phase, 4);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        expect_phase("t2.SG",  4, 7, 4'b1000, 4'b0010);
        expect_phase("t2.SY",  5, 2, 4'b1000, 4'b0100);
        expect_phase("t2.AR2", 0, 1, 4'b1000, 4'b1000);
        chk("t2.ack_entry", ped_ack, 1);
        a0 = ack_cnt;
        expect_phase("t2.WALK", 6, 4, 4'b1001, 4'b1001);
        chk("t2.ack_count", ack_cnt - a0, 1);

        // emergency raised at main-green tick 3
        chk("t3.mg", phase, 1);
        repeat (3) step();
        emerg = 1'b1;
        step();
        expect_phase("t3.MY", 2, 2, 4'b0100, 4'b1000);
        for (int i = 0; i < 5; i++) begin
            chk("t3.emrg_hold", phase, 7);
            chk("t3.emrg_lamp", main_light, 4'b1000);
            step();
        end
        emerg = 1'b0;
        expect_phase("t3.EMRG", 7, 1, 4'b1000, 4'b1000);
        chk("t3.mg_after", phase, 1);

        // emergency during walk with a fresh pedestrian request
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        expect_phase("t4.MG",  1, 7, 4'b0010, 4'b1000);
        expect_phase("t4.MY",  2, 2, 4'b0100, 4'b1000);
        expect_phase("t4.AR1", 3, 1, 4'b1000, 4'b1000);
        expect_phase("t4.SG",  4, 8, 4'b1000, 4'b0010);
        expect_phase("t4.SY",  5, 2, 4'b1000, 4'b0100);
        expect_phase("t4.AR2", 0, 1, 4'b1000, 4'b1000);
        chk("t4.ack_entry", ped_ack, 1);
        step();
        chk("t4.walk", phase, 6);
        emerg = 1'b1;
        ped_req = 1'b1;
        step();
        chk("t4.emrg", phase, 7);
        chk("t4.no_ack", ped_ack, 0);
        emerg = 1'b0;
        ped_req = 1'b0;
        a0 = ack_cnt;
        expect_phase("t4.EMRG", 7, 1, 4'b1000, 4'b1000);
        normal_cycle_from_mg("t4b");
        chk("t4.no_extra_ack", ack_cnt - a0, 0);
        chk("t4.ack_rewalk", ped_ack, 1);
        expect_phase("t4.WALK", 6, 4, 4'b1001, 4'b1001);

        // slow tick, then async reset mid side-green
        mode3 = 1'b1; divc = 0; tick = 1'b0;
        expect_phase("t5.MG",  1, 24, 4'b0010, 4'b1000);
        expect_phase("t5.MY",  2, 6,  4'b0100, 4'b1000);
        expect_phase("t5.AR1", 3, 3,  4'b1000, 4'b1000);
        repeat (4) step();
        chk("t5.sg", phase, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("t5.rst_phase", phase, 0);
        chk("t5.rst_main", main_light, 4'b1000);
        chk("t5.rst_side", side_light, 4'b1000);
        chk("t5.rst_ack", ped_ack, 0);
        mode3 = 1'b0;
        tick = 1'b1;
        repeat (2) step();
        chk("t5.rst_hold", phase, 0);
        rst_n = 1'b1;
        expect_phase("t5.AR2", 0, 1, 4'b1000, 4'b1000);
        expect_phase("t5.MG2", 1, 8, 4'b0010, 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
